// File: rtl/udp128_payload_tx_if.sv
// Purpose: groups the packet-metadata, word-request and byte-stream signals of udp128_payload_tx.
// Latency: none (plain wires); the DUT owns all timing.
// Backpressure: byte stream is valid/ready (o_tx_valid/i_tx_ready); word fetch is request/response.
interface udp128_payload_tx_if;
  // packet metadata from the command stage
  logic         i_start;
  logic         i_last_frame_flag;
  logic [14:0]  i_frame_rank;
  logic [15:0]  i_jpeg_len;
  logic [15:0]  i_ipv4_sign;
  // payload word fetch
  logic         o_req;
  logic [6:0]   o_req_rank;
  logic         i_word_vld;
  logic [127:0] i_word;
  // byte stream toward the UDP/MAC transmitter
  logic         o_tx_valid;
  logic [7:0]   o_tx_data;
  logic         o_tx_sof;
  logic         o_tx_eof;
  logic         i_tx_ready;
  // status
  logic         o_frame_down;
  logic         o_busy;
  logic [3:0]   o_state;
  logic         o_error;

  // DUT side
  modport slave (
    input  i_start, i_last_frame_flag, i_frame_rank, i_jpeg_len, i_ipv4_sign,
    input  i_word_vld, i_word, i_tx_ready,
    output o_req, o_req_rank, o_tx_valid, o_tx_data, o_tx_sof, o_tx_eof,
    output o_frame_down, o_busy, o_state, o_error
  );

  // upstream / transmitter side
  modport master (
    output i_start, i_last_frame_flag, i_frame_rank, i_jpeg_len, i_ipv4_sign,
    output i_word_vld, i_word, i_tx_ready,
    input  o_req, o_req_rank, o_tx_valid, o_tx_data, o_tx_sof, o_tx_eof,
    input  o_frame_down, o_busy, o_state, o_error
  );
endinterface

// File: rtl/udp128_payload_tx.sv
// Purpose: per packet, emits an 8-byte app header then fetches 128-bit payload words by rank and
//          serializes them MSB byte first; pulses o_frame_down when the packet is done.
// Latency: i_start -> first header byte 1 cycle; i_word_vld -> first word byte 1 cycle.
// Backpressure: byte outputs hold stable while o_tx_valid && !i_tx_ready; all outputs registered.
// Ports: i_clk, i_rst_n (async active-low), bus (udp128_payload_tx_if.slave: metadata, word
//        request/response, byte stream, status).
module udp128_payload_tx #(
  parameter int MAX_PAYLOAD_BYTES = 1024
) (
  input logic                i_clk,
  input logic                i_rst_n,
  udp128_payload_tx_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR   = 4'd1,
    S_REQ   = 4'd2,
    S_WAIT  = 4'd3,
    S_SHIFT = 4'd4,
    S_DONE  = 4'd5
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  seq_q, seq_d;
  logic [15:0]  len_q, len_d;
  logic [6:0]   rank_q, rank_d;
  logic [127:0] sh_q, sh_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         vld_q, vld_d;
  logic         sof_q, sof_d;
  logic         eof_q, eof_d;
  logic         req_q, req_d;
  logic [6:0]   req_rank_q, req_rank_d;
  logic         fd_q, fd_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  logic         too_long;
  logic         word_last;
  logic [3:0]   last_idx;
  logic         accept;

  // 2048 bytes is the most a 7-bit word rank can address.
  assign too_long = ({16'd0, bus.i_jpeg_len} > 32'(MAX_PAYLOAD_BYTES)) ||
                    (bus.i_jpeg_len > 16'd2048);

  // Current word is the final one when the bytes through its end cover len.
  assign word_last = (({6'd0, rank_q, 4'd0} + 17'd16) >= {1'b0, len_q});
  // 16*rank has no low bits, so the tail length mod 16 is len[3:0] (0 meaning a full word).
  assign last_idx  = word_last ? (len_q[3:0] - 4'd1) : 4'd15;
  assign accept    = vld_q & bus.i_tx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      seq_q      <= 16'd0;
      len_q      <= 16'd0;
      rank_q     <= 7'd0;
      sh_q       <= 128'd0;
      cnt_q      <= 4'd0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      req_q      <= 1'b0;
      req_rank_q <= 7'd0;
      fd_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      len_q      <= len_d;
      rank_q     <= rank_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      req_q      <= req_d;
      req_rank_q <= req_rank_d;
      fd_q       <= fd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    len_d      = len_q;
    rank_d     = rank_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    vld_d      = vld_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    req_d      = 1'b0;
    req_rank_d = req_rank_q;
    fd_d       = 1'b0;
    // protocol violations are sticky until reset
    err_d      = err_q | (bus.i_start && (state_q != S_IDLE))
                       | (bus.i_word_vld && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          len_d  = bus.i_jpeg_len;
          rank_d = 7'd0;
          cnt_d  = 4'd0;
          if (too_long) begin
            err_d   = 1'b1;
            fd_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            // header rides in the top half of the shift register, byte 0 in [127:120]
            sh_d    = {bus.i_last_frame_flag, bus.i_frame_rank, bus.i_jpeg_len,
                       bus.i_ipv4_sign, seq_q, 64'd0};
            vld_d   = 1'b1;
            sof_d   = 1'b1;
            eof_d   = 1'b0;
            state_d = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (accept) begin
          if (cnt_q == 4'd7) begin
            vld_d = 1'b0;
            sof_d = 1'b0;
            eof_d = 1'b0;
            cnt_d = 4'd0;
            if (len_q == 16'd0) begin
              fd_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              rank_d     = 7'd0;
              req_d      = 1'b1;
              req_rank_d = 7'd0;
              state_d    = S_REQ;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
            sh_d  = {sh_q[119:0], 8'd0};
            sof_d = 1'b0;
            eof_d = (cnt_q == 4'd6) && (len_q == 16'd0);
          end
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.i_word_vld) begin
          sh_d    = bus.i_word;
          vld_d   = 1'b1;
          cnt_d   = 4'd0;
          eof_d   = word_last && (last_idx == 4'd0);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (accept) begin
          if (cnt_q == last_idx) begin
            vld_d = 1'b0;
            eof_d = 1'b0;
            cnt_d = 4'd0;
            if (word_last) begin
              fd_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              rank_d     = rank_q + 7'd1;
              req_d      = 1'b1;
              req_rank_d = rank_q + 7'd1;
              state_d    = S_REQ;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
            sh_d  = {sh_q[119:0], 8'd0};
            eof_d = word_last && ((cnt_q + 4'd1) == last_idx);
          end
        end
      end

      S_DONE: begin
        seq_d   = seq_q + 16'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.o_req        = req_q;
  assign bus.o_req_rank   = req_rank_q;
  assign bus.o_tx_valid   = vld_q;
  assign bus.o_tx_data    = sh_q[127:120];
  assign bus.o_tx_sof     = sof_q;
  assign bus.o_tx_eof     = eof_q;
  assign bus.o_frame_down = fd_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_state      = state_q;
  assign bus.o_error      = err_q;

endmodule

// File: tb/tb_udp128_payload_tx.sv
// Purpose: randomized self-checking bench for udp128_payload_tx against a byte-list reference.
// Latency: checks start->sof, word->first byte, header->req and last byte->frame_down timing.
// Backpressure: drives random i_tx_ready and checks outputs hold while stalled.
module tb_udp128_payload_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [15:0] exp_seq = 16'd0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp128_payload_tx_if bus();

  udp128_payload_tx #(.MAX_PAYLOAD_BYTES(1024)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] outs_vec();
    return {bus.o_tx_valid, bus.o_tx_data, bus.o_tx_sof, bus.o_tx_eof, bus.o_req,
            bus.o_req_rank, bus.o_frame_down, bus.o_busy, bus.o_state, bus.o_error};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_word_vld = 1'b0;
    bus.i_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", outs_vec(), 0);
    rst_n = 1'b1;
    exp_seq = 16'd0;
    exp_err = 1'b0;
    @(negedge clk);
    check_val("idle_after_reset", outs_vec(), 0);
  endtask

  // Runs one packet from i_start to o_frame_down. abort_idx >= 0 pulls reset when the
  // stream reaches that global byte index and returns without end-of-packet checks.
  task automatic run_packet(input int len, input logic [14:0] frank, input logic lastf,
                            input logic [15:0] sign, input int ready_pct, input int lat,
                            input int abort_idx);
    logic [127:0] words[$];
    logic [7:0]   exp_b[$];
    logic [63:0]  hdr;
    logic [15:0]  len16;
    logic [10:0]  hold;
    logic [127:0] w;
    bit           bad, hold_pend, seen_vld, wchk, wnext;
    int           nw, total, idx, s, req_cnt, due, wi, fd_cnt, fd_exp, post;

    len16 = len[15:0];
    bad   = (len > 1024);
    nw    = bad ? 0 : (len + 15) / 16;
    for (int i = 0; i < nw; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      words.push_back(w);
    end
    if (!bad) begin
      hdr = {lastf, frank, len16, sign, exp_seq};
      for (int i = 0; i < 8; i++) exp_b.push_back(hdr[63 - 8*i -: 8]);
      for (int k = 0; k < len; k++) begin
        w = words[k / 16];
        exp_b.push_back(w[127 - 8*(k % 16) -: 8]);
      end
    end
    total = exp_b.size();

    idx = 0; req_cnt = 0; due = -1; wi = 0; fd_cnt = 0; fd_exp = -1; post = 0;
    hold_pend = 0; seen_vld = 0; wnext = 0; hold = '0;

    bus.i_start = 1'b1;
    bus.i_last_frame_flag = lastf;
    bus.i_frame_rank = frank;
    bus.i_jpeg_len = len16;
    bus.i_ipv4_sign = sign;
    s = cyc;
    if (bad) fd_exp = s + 1;
    @(negedge clk);
    bus.i_start = 1'b0;

    for (int t = 0; t < 30000 && post < 2; t++) begin
      // drive this cycle's inputs
      wchk = wnext;
      wnext = 0;
      bus.i_tx_ready = ($urandom_range(99) < ready_pct);
      bus.i_word_vld = 1'b0;
      if (due == cyc) begin
        if (wi < words.size()) begin
          bus.i_word = words[wi];
          wi++;
        end
        bus.i_word_vld = 1'b1;
        wnext = 1;
        due = -1;
      end

      // observe
      if (wchk) check_val("word_lat", bus.o_tx_valid, 1'b1);
      if (hold_pend) begin
        check_val("stall_hold", {bus.o_tx_valid, bus.o_tx_sof, bus.o_tx_eof, bus.o_tx_data}, hold);
        hold_pend = 0;
      end
      if (abort_idx >= 0 && idx == abort_idx && bus.o_tx_valid) begin
        #2 rst_n = 1'b0;
        #1 check_val("async_reset", outs_vec(), 0);
        bus.i_word_vld = 1'b0;
        bus.i_tx_ready = 1'b0;
        exp_seq = 16'd0;
        exp_err = 1'b0;
        @(negedge clk);
        check_val("held_in_reset", outs_vec(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (bus.o_tx_valid) begin
        if (!seen_vld) begin
          seen_vld = 1;
          check_val("sof_lat", cyc, s + 1);
        end
        if (bus.i_tx_ready) begin
          if (idx >= total) begin
            check_val("extra_byte", idx, total - 1);
          end else begin
            check_val($sformatf("byte%0d", idx), {bus.o_tx_sof, bus.o_tx_eof, bus.o_tx_data},
                      {idx == 0, idx == total - 1, exp_b[idx]});
          end
          idx++;
          if (idx == total) fd_exp = cyc + 1;
        end else begin
          hold_pend = 1;
          hold = {1'b1, bus.o_tx_sof, bus.o_tx_eof, bus.o_tx_data};
        end
      end
      if (bus.o_req) begin
        check_val("req_rank", bus.o_req_rank, req_cnt);
        if (req_cnt == 0 && ready_pct >= 100) check_val("req_lat", cyc, s + 9);
        req_cnt++;
        due = cyc + lat;
      end
      if (bus.o_frame_down) begin
        fd_cnt++;
        check_val("fd_cyc", cyc, fd_exp);
      end
      if (fd_cnt > 0) post++;
      @(negedge clk);
    end

    if (bad) exp_err = 1'b1;
    check_val("fd_count", fd_cnt, 1);
    check_val("byte_count", idx, total);
    check_val("req_count", req_cnt, nw);
    check_val("idle_state", {bus.o_busy, bus.o_state}, 5'd0);
    check_val("err_flag", bus.o_error, exp_err);
    exp_seq = exp_seq + 16'd1;
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_last_frame_flag = 1'b0;
    bus.i_frame_rank = '0;
    bus.i_jpeg_len = '0;
    bus.i_ipv4_sign = '0;
    bus.i_word_vld = 1'b0;
    bus.i_word = '0;
    bus.i_tx_ready = 1'b0;

    do_reset();
    // header 80 05 00 20 12 34 00 00, two words
    run_packet(32, 15'd5, 1'b1, 16'h1234, 100, 3, -1);
    // short final word of 4 bytes
    run_packet(20, 15'($urandom()), 1'($urandom()), 16'($urandom()), 100, 2, -1);
    // header only
    run_packet(0, 15'($urandom()), 1'($urandom()), 16'($urandom()), 100, 1, -1);
    // maximum length under random backpressure
    run_packet(1024, 15'($urandom()), 1'($urandom()), 16'($urandom()), 50,
               int'($urandom_range(1, 4)), -1);
    check_val("no_error", bus.o_error, 1'b0);

    do_reset();
    run_packet(1040, 15'd7, 1'b0, 16'hBEEF, 100, 1, -1);
    run_packet(48, 15'($urandom()), 1'($urandom()), 16'($urandom()), 100, 2, -1);
    for (int i = 0; i < 5; i++) begin
      run_packet(int'($urandom_range(1, 300)), 15'($urandom()), 1'($urandom()),
                 16'($urandom()), 70, int'($urandom_range(1, 4)), -1);
    end

    // reset during word 2 of a 64-byte packet, then a packet that must restart seq at 0
    run_packet(64, 15'd9, 1'b0, 16'h0F0F, 100, 2, 8 + 32 + 5);
    run_packet(16, 15'($urandom()), 1'($urandom()), 16'($urandom()), 100, 1, -1);

    // stray word strobe while idle
    bus.i_word_vld = 1'b1;
    @(negedge clk);
    bus.i_word_vld = 1'b0;
    check_val("spurious_word_err", bus.o_error, 1'b1);
    @(negedge clk);
    check_val("idle_no_output", {bus.o_tx_valid, bus.o_req, bus.o_frame_down}, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/udp128_payload_tx.md
# udp128_payload_tx

Downstream consumer of the 128-bit UDP payload interface produced by the DPB master/command stage. Per packet, it latches the packet metadata and emits an 8-byte application header as a byte stream toward the UDP/MAC transmitter. It then requests the payload 128-bit words one at a time by rank, serializes each word MSB-byte first, and reports packet completion back upstream.

## Interface
- MAX_PAYLOAD_BYTES, 1024: largest legal `i_jpeg_len`; must be a multiple of 16 and ≤ 2048.
- i_clk  in  1  single clock (same domain as upstream 128-bit interface).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse: packet metadata valid (upstream `o_udp128_en`).
- i_last_frame_flag  in  1  packet is last of JPEG frame.
- i_frame_rank  in  15  MJPEG frame rank.
- i_jpeg_len  in  16  payload bytes in this packet.
- i_ipv4_sign  in  16  IPv4 identification.
- o_req  out  1  one-cycle word request (upstream `i_udp128_ddr3_data_upd_req`).
- o_req_rank  out  7  index of requested 128-bit word.
- i_word_vld  in  1  one-cycle pulse: `i_word` valid.
- i_word  in  128  payload word, byte 0 = [127:120].
- o_tx_valid  out  1  byte valid to transmitter.
- o_tx_data  out  8  byte.
- o_tx_sof  out  1  first byte of packet (qualified by valid).
- o_tx_eof  out  1  last byte of packet (qualified by valid).
- i_tx_ready  in  1  transmitter accepts byte when valid & ready.
- o_frame_down  out  1  one-cycle pulse: packet finished (upstream `i_udp128_udp_frame_down`).
- o_busy  out  1  high in any state except IDLE.
- o_state  out  4  state encoding: IDLE=0, HDR=1, REQ=2, WAIT=3, SHIFT=4, DONE=5.
- o_error  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE → HDR → (REQ → WAIT → SHIFT)* → DONE → IDLE.
- IDLE: on `i_start`, latch all metadata and go to HDR. `i_start` in any other state is ignored and sets `o_error`.
- HDR: emits 8 bytes, big-endian:
  - bytes 0-1: {last_flag, frame_rank}
  - bytes 2-3: jpeg_len
  - bytes 4-5: ipv4_sign
  - bytes 6-7: seq[15:0]
- Header exit after byte 7 accepted: if len==0, go to DONE (byte 7 carries `o_tx_eof`); otherwise go to REQ with word rank 0.
- REQ: `o_req`=1 for exactly one cycle with `o_req_rank`=current rank; next state WAIT.
- WAIT: holds until `i_word_vld`; then captures `i_word` into the shift register and goes to SHIFT. No timeout.
- SHIFT: emits bytes [127:120] first.
  - Byte count for the word = 16, except the final word (rank = ceil(len/16)−1), which emits len−16·rank bytes (1..16).
  - After the word's last byte is accepted: if more words remain, rank+1 and go to REQ; else go to DONE.
- `o_tx_eof` accompanies global byte number 8+len−1.
- DONE: `o_frame_down`=1 for one cycle, seq ← seq+1 (wraps 0xFFFF→0), then IDLE.
- Over-length packet (len > MAX_PAYLOAD_BYTES, or len not representable in 7-bit rank): set `o_error`, emit nothing, go directly to DONE (`o_frame_down` still pulses, seq still increments).
- `i_word_vld` outside WAIT: ignored, sets `o_error`.
- Backpressure: while `o_tx_valid`&&!`i_tx_ready`, `o_tx_data`/`o_tx_sof`/`o_tx_eof` stay stable; the byte counter does not advance.

## Timing
- Reset values:
  - all outputs 0; `o_state`=IDLE
  - seq=0, shift register=0, rank=0
- Reset mid-packet aborts immediately: no `o_frame_down`, no `o_tx_eof`; seq returns to 0.
- Latency:
  - `i_start` at cycle N → `o_tx_valid`&&`o_tx_sof` at N+1.
  - With `i_tx_ready` tied high, header bytes occupy N+1..N+8; `o_req` is at N+9.
  - `i_word_vld` at cycle M → first byte of the word at M+1.
- Per-word overhead with ready high: 1 cycle REQ plus upstream latency; SHIFT then emits 1 byte/cycle.
- `o_frame_down` is asserted the cycle after the final byte is accepted.
- All outputs are registered; no combinational path from `i_tx_ready` to `o_tx_data`.

## Test plan
- Start len=32, rank=5, last=1, sign=0x1234, ready=1, word latency 3:
  - header bytes 80 05 00 20 12 34 00 00
  - two `o_req` pulses with rank 0 then 1
  - 32 payload bytes in order; eof on byte 39
  - `o_frame_down` once; seq→1
- len=20: second word emits only 4 bytes (word1[127:96]); eof on byte 27; total 28 valid-ready transfers.
- len=0: 8 header bytes, eof on byte 7, no `o_req`, `o_frame_down` next cycle.
- Random `i_tx_ready` (50%) with len=1024: data stable while stalled; 1032 bytes in order; `o_req_rank` runs 0..63.
- len=1040: `o_error`=1, no `o_tx_valid`, `o_frame_down` pulses; followed by a valid packet whose seq byte 7 = 0x01.
- Assert `i_rst_n`=0 during SHIFT of word 2: all outputs 0 asynchronously; the next packet's seq = 0; spurious `i_word_vld` in IDLE sets `o_error`.
